tape_ram_injector: RTL and testbench

//  Sits directly downstream of the cassette TAP parser. Converts its loose write stream (tape_addr/tape_dout

---
 rtl/tape_ram_injector_pkg.sv | 15 +
 rtl/tape_ram_injector_if.sv | 28 ++
 rtl/tape_wr_fifo.sv | 48 ++++
 rtl/tape_ram_injector.sv | 146 ++++++++++++++
 tb/tb_tape_ram_injector.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tape_ram_injector_pkg.sv
// Shared constants for the cassette-to-RAM write injector: default widths, FSM encoding
// and the Lynx RAM load base address.
package tape_ram_injector_pkg;

    localparam int unsigned ADDR_W_DEF     = 16;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned DEPTH_LOG2_DEF = 4;

    localparam logic [15:0] LYNX_RAM_BASE = 16'h694D;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/tape_ram_injector_if.sv
// Shared main-RAM write port: request/grant handshake plus address, data and write strobe.
interface tape_ram_injector_if #(
    parameter int unsigned ADDR_W = 16
) ();

    logic              ram_req;
    logic              ram_gnt;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              ram_we;

    modport master (
        output ram_req,
        output ram_addr,
        output ram_din,
        output ram_we,
        input  ram_gnt
    );

    modport slave (
        input  ram_req,
        input  ram_addr,
        input  ram_din,
        input  ram_we,
        output ram_gnt
    );

endinterface

// File: rtl/tape_wr_fifo.sv
// Synchronous FIFO buffering captured tape writes; a full FIFO still accepts a push
// in the same cycle as a pop, since the pop frees the slot.
module tape_wr_fifo #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset; contents are only read behind valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
    end

endmodule

// File: rtl/tape_ram_injector.sv
// Turns the TAP parser's level-qualified write stream into discrete FIFO-buffered writes
// and injects them into the shared RAM port on CPU grant, with load progress reporting.
module tape_ram_injector
    import tape_ram_injector_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tape_wr,
    input  logic [ADDR_W-1:0]    tape_addr,
    input  logic [7:0]           tape_dout,
    input  logic                 load_active,
    tape_ram_injector_if.master  ram,
    output logic                 busy,
    output logic [15:0]          byte_count,
    output logic                 overflow
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    logic [1:0]         state, state_n;
    logic               tape_wr_q;
    logic [ADDR_W-1:0]  last_addr;
    logic               load_q;

    logic               req_q, req_n;
    logic               we_q, we_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic [7:0]         din_q, din_n;
    logic [15:0]        count_n;
    logic               ovf_n;
    logic               busy_n;

    logic               capture, push, pop, load_rise, ovf_evt;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] head;

    assign ram.ram_req  = req_q;
    assign ram.ram_we   = we_q;
    assign ram.ram_addr = addr_q;
    assign ram.ram_din  = din_q;

    tape_wr_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({tape_addr, tape_dout}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            tape_wr_q  <= 1'b0;
            last_addr  <= '0;
            load_q     <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            busy       <= 1'b0;
            byte_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            tape_wr_q  <= tape_wr;
            load_q     <= load_active;
            if (capture) last_addr <= tape_addr;
            req_q      <= req_n;
            we_q       <= we_n;
            addr_q     <= addr_n;
            din_q      <= din_n;
            busy       <= busy_n;
            byte_count <= count_n;
            overflow   <= ovf_n;
        end
    end

    // Next-state, capture qualification and registered-output next values.
    always_comb begin
        state_n   = state;
        req_n     = req_q;
        we_n      = 1'b0;
        addr_n    = addr_q;
        din_n     = din_q;
        pop       = 1'b0;

        capture   = tape_wr && (!tape_wr_q || (tape_addr != last_addr));
        load_rise = load_active && !load_q;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    {addr_n, din_n} = head;
                    req_n           = 1'b1;
                    state_n         = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ram.ram_gnt) begin
                    we_n    = 1'b1;
                    pop     = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!fifo_empty) begin
                    {addr_n, din_n} = head;
                    req_n           = 1'b1;
                    state_n         = ST_REQ;
                end else begin
                    req_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                req_n   = 1'b0;
                state_n = ST_IDLE;
            end
        endcase

        push    = capture && (!fifo_full || pop);
        ovf_evt = capture && fifo_full && !pop;

        if (load_rise)
            count_n = '0;
        else if (pop && (byte_count != 16'hFFFF))
            count_n = byte_count + 16'd1;
        else
            count_n = byte_count;

        ovf_n  = (load_rise ? 1'b0 : overflow) | ovf_evt;

        // A pop always moves the FSM to DONE, so only the push can make an empty FIFO busy.
        busy_n = (state_n != ST_IDLE) || !fifo_empty || push;
    end

endmodule

// File: tb/tb_tape_ram_injector.sv
// Directed bench for tape_ram_injector: capture rules, FIFO overflow, grant handshake and reset.
module tb_tape_ram_injector;
    import tape_ram_injector_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tape_wr = 1'b0;
    logic [15:0] tape_addr = '0;
    logic [7:0]  tape_dout = '0;
    logic        load_active = 1'b0;
    logic        busy;
    logic [15:0] byte_count;
    logic        overflow;

    tape_ram_injector_if #(.ADDR_W(16)) bus ();

    tape_ram_injector #(.DEPTH_LOG2(4), .ADDR_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .tape_wr     (tape_wr),
        .tape_addr   (tape_addr),
        .tape_dout   (tape_dout),
        .load_active (load_active),
        .ram         (bus.master),
        .busy        (busy),
        .byte_count  (byte_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bus monitor: logs writes, flags writes not preceded by a granted request and
    // address/data changes while a request is pending.
    int          we_cnt = 0;
    int          viol_gnt = 0;
    int          viol_stable = 0;
    logic [23:0] wlog[$];
    logic        p_req = 1'b0;
    logic        p_we = 1'b0;
    logic        p_gnt = 1'b0;
    logic [15:0] p_addr = '0;
    logic [7:0]  p_din = '0;

    always @(negedge clk) begin
        if (reset) begin
            p_req <= 1'b0;
            p_we  <= 1'b0;
            p_gnt <= 1'b0;
        end else begin
            if (bus.ram_we) begin
                we_cnt <= we_cnt + 1;
                wlog.push_back({bus.ram_addr, bus.ram_din});
                if (!(p_gnt && p_req)) viol_gnt <= viol_gnt + 1;
            end
            if (p_req && bus.ram_req && !p_we &&
                ((bus.ram_addr != p_addr) || (bus.ram_din != p_din)))
                viol_stable <= viol_stable + 1;
            p_req  <= bus.ram_req;
            p_we   <= bus.ram_we;
            p_gnt  <= bus.ram_gnt;
            p_addr <= bus.ram_addr;
            p_din  <= bus.ram_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare n logged writes from index base against addr0+i / data0+i.
    task automatic check_log(input string tag, input int base, input int n,
                             input logic [15:0] addr0, input logic [7:0] data0);
        logic [31:0] obs;
        for (int i = 0; i < n; i++) begin
            obs = ((base + i) < wlog.size()) ? {8'h00, wlog[base + i]} : 32'hFFFF_FFFF;
            check($sformatf("%s[%0d]", tag, i), obs,
                  {8'h00, addr0 + 16'(i), data0 + 8'(i)});
        end
    endtask

    task automatic load_restart();
        load_active = 1'b0;
        tick(2);
        load_active = 1'b1;
        tick(1);
    endtask

    int base;

    initial begin
        bus.ram_gnt = 1'b0;
        tick(3);
        check("rst_req_in_reset", {31'd0, bus.ram_req}, 32'd0);
        reset = 1'b0;
        tick(1);
        check("rst_req",   {31'd0, bus.ram_req}, 32'd0);
        check("rst_we",    {31'd0, bus.ram_we},  32'd0);
        check("rst_addr",  {16'd0, bus.ram_addr}, 32'd0);
        check("rst_din",   {24'd0, bus.ram_din}, 32'd0);
        check("rst_busy",  {31'd0, busy},        32'd0);
        check("rst_count", {16'd0, byte_count},  32'd0);
        check("rst_ovf",   {31'd0, overflow},    32'd0);
        load_active = 1'b1;
        tick(2);

        // Single byte with grant tied high
        bus.ram_gnt = 1'b1;
        base = we_cnt;
        tape_wr = 1'b1; tape_addr = LYNX_RAM_BASE; tape_dout = 8'hA5;
        tick(1);
        tape_wr = 1'b0;
        check("t1_busy_early", {31'd0, busy}, 32'd1);
        check("t1_no_we_yet", {31'd0, bus.ram_we}, 32'd0);
        tick(8);
        check("t1_writes", we_cnt - base, 32'd1);
        check_log("t1_log", base, 1, 16'h694D, 8'hA5);
        check("t1_count", {16'd0, byte_count}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // Held tape_wr, address steps every 4 cycles
        base = we_cnt;
        tape_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tape_addr = 16'h694D + 16'(i);
            tape_dout = 8'h10 + 8'(i);
            tick(4);
        end
        tape_wr = 1'b0;
        tick(8);
        check("t2_writes", we_cnt - base, 32'd5);
        check_log("t2_log", base, 5, 16'h694D, 8'h10);
        check("t2_count", {16'd0, byte_count}, 32'd6);

        // Grant starved: 20 captures into a 16-deep FIFO
        load_restart();
        check("t3_count_clr", {16'd0, byte_count}, 32'd0);
        bus.ram_gnt = 1'b0;
        base = we_cnt;
        tape_wr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tape_addr = 16'h7000 + 16'(i);
            tape_dout = 8'(i);
            tick(1);
        end
        tape_wr = 1'b0;
        tick(20);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        check("t3_busy", {31'd0, busy}, 32'd1);
        check("t3_req", {31'd0, bus.ram_req}, 32'd1);
        check("t3_no_writes", we_cnt - base, 32'd0);
        bus.ram_gnt = 1'b1;
        tick(40);
        check("t3_writes", we_cnt - base, 32'd16);
        check_log("t3_log", base, 16, 16'h7000, 8'h00);
        check("t3_count", {16'd0, byte_count}, 32'd16);
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Full FIFO with pop and capture in the same cycle
        bus.ram_gnt = 1'b0;
        load_restart();
        check("t4_ovf_clr", {31'd0, overflow}, 32'd0);
        base = we_cnt;
        tape_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tape_addr = 16'h7100 + 16'(i);
            tape_dout = 8'h40 + 8'(i);
            tick(1);
        end
        tape_addr = 16'h7110; tape_dout = 8'h50; bus.ram_gnt = 1'b1;
        tick(1);
        tape_wr = 1'b0; bus.ram_gnt = 1'b0;
        tick(2);
        check("t4_ovf_pop_push", {31'd0, overflow}, 32'd0);
        tape_wr = 1'b1; tape_addr = 16'h7111; tape_dout = 8'h51;
        tick(1);
        tape_wr = 1'b0;
        check("t4_still_full", {31'd0, overflow}, 32'd1);
        bus.ram_gnt = 1'b1;
        tick(45);
        check("t4_writes", we_cnt - base, 32'd17);
        check_log("t4_log", base, 17, 16'h7100, 8'h40);
        check("t4_count", {16'd0, byte_count}, 32'd17);

        // Grant asserted one cycle in three
        bus.ram_gnt = 1'b0;
        load_restart();
        base = we_cnt;
        for (int c = 0; c < 30; c++) begin
            bus.ram_gnt = ((c % 3) == 0);
            tape_wr = (c < 4);
            tape_addr = 16'h7200 + 16'(c);
            tape_dout = 8'h60 + 8'(c);
            tick(1);
        end
        bus.ram_gnt = 1'b0;
        tape_wr = 1'b0;
        tick(2);
        check("t5_writes", we_cnt - base, 32'd4);
        check_log("t5_log", base, 4, 16'h7200, 8'h60);
        check("t5_count", {16'd0, byte_count}, 32'd4);
        check("t5_busy", {31'd0, busy}, 32'd0);

        // Async reset while requesting with entries queued
        base = we_cnt;
        tape_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tape_addr = 16'h7300 + 16'(i);
            tape_dout = 8'h70 + 8'(i);
            tick(1);
        end
        tape_wr = 1'b0;
        tick(3);
        check("t6_req_before", {31'd0, bus.ram_req}, 32'd1);
        #3 reset = 1'b1;
        #1;
        check("t6_req_async",   {31'd0, bus.ram_req}, 32'd0);
        check("t6_we_async",    {31'd0, bus.ram_we},  32'd0);
        check("t6_addr_async",  {16'd0, bus.ram_addr}, 32'd0);
        check("t6_busy_async",  {31'd0, busy},        32'd0);
        check("t6_count_async", {16'd0, byte_count},  32'd0);
        bus.ram_gnt = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(12);
        check("t6_no_writes", we_cnt - base, 32'd0);
        check("t6_busy_after", {31'd0, busy}, 32'd0);
        base = we_cnt;
        tape_wr = 1'b1; tape_addr = LYNX_RAM_BASE; tape_dout = 8'h77;
        tick(1);
        tape_wr = 1'b0;
        tick(8);
        check_log("t6_log", base, 1, 16'h694D, 8'h77);
        check("t6_count_one", {16'd0, byte_count}, 32'd1);
        load_active = 1'b0;
        tick(3);
        check("t6_fall_keeps", {16'd0, byte_count}, 32'd1);
        load_active = 1'b1;
        tick(2);
        check("t6_rise_clears", {16'd0, byte_count}, 32'd0);

        check("mon_we_without_gnt", viol_gnt, 32'd0);
        check("mon_unstable_req", viol_stable, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
